// File: rtl/linebuf_pkg.sv
// Shared constants and types for the KxK sliding-window line buffer.
// Contents: default pixel width / window size and the default pixel type.
package linebuf_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned K_DEF  = 3;

  typedef logic [DW_DEF-1:0] pix_t;

endpackage

// File: rtl/linebuf_line_delay.sv
// line_delay: enabled shift register used as one image-row delay.
// Ports:
//   clk   rising-edge clock
//   en    shift enable (one accepted pixel)
//   din   pixel entering the delay
//   dout  pixel accepted DEPTH enables earlier
// Contents are deliberately not reset; the consumer gates validity with counters.
module line_delay
  import linebuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DW_DEF
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  // Shift one stage per accepted pixel
  always_ff @(posedge clk) begin
    if (en) begin
      sr[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/linebuffer_kxk.sv
// linebuffer_kxk: streaming KxK sliding-window generator for raster pixels.
// Emits a window only when it lies fully inside the image.
// Ports:
//   clk, rst           clock / asynchronous active-high reset
//   in_valid, in_data  accepted raster-order pixel stream
//   win_valid          one-cycle pulse per emitted window
//   win_data           window, index r*K+c, index 0 = top-left (oldest)
//   win_row, win_col   image coordinates of the window's bottom-right pixel
//   frame_done         pulse registered with the last pixel of a frame
// Build option: define LINEBUF_STRIDE2_EN to emit only stride-2 windows.
module linebuffer_kxk
  import linebuf_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned K     = K_DEF,
  parameter int unsigned IMG_W = 4,
  parameter int unsigned IMG_H = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DW-1:0]                in_data,
  output logic                         win_valid,
  output logic [K*K-1:0][DW-1:0]       win_data,
  output logic [$clog2(IMG_H)-1:0]     win_row,
  output logic [$clog2(IMG_W)-1:0]     win_col,
  output logic                         frame_done
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          last_col;
  logic          last_row;
  logic          in_win;

  // dly[0] is the live pixel; dly[j] is the pixel j rows back
  logic [DW-1:0] dly [K];

  assign dly[0] = in_data;

  genvar j;
  generate
    for (j = 1; j < int'(K); j++) begin : g_delay
      line_delay #(
        .DEPTH (IMG_W),
        .WIDTH (DW)
      ) u_delay (
        .clk  (clk),
        .en   (in_valid),
        .din  (dly[j-1]),
        .dout (dly[j])
      );
    end
  endgenerate

`ifdef LINEBUF_STRIDE2_EN
  // Parity of K-1: row/col offsets from K-1 are even when parity matches
  localparam logic KPAR = 1'((K - 1) % 2);
`endif

  // Position decode for the pixel being accepted
  always_comb begin
    last_col = (col_q == CW'(IMG_W - 1));
    last_row = (row_q == RW'(IMG_H - 1));
    in_win   = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
`ifdef LINEBUF_STRIDE2_EN
    in_win   = in_win && (row_q[0] == KPAR) && (col_q[0] == KPAR);
`endif
  end

  // Counters, window array and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_data   <= '0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        win_valid  <= in_win;
        frame_done <= last_row && last_col;
        win_row    <= row_q;
        win_col    <= col_q;
        // Columns move toward c=0; row K-1-r takes the pixel r rows back
        for (int r = 0; r < int'(K); r++) begin
          for (int c = 0; c < int'(K); c++) begin
            if (c == int'(K) - 1) begin
              win_data[r*int'(K)+c] <= dly[int'(K)-1-r];
            end else begin
              win_data[r*int'(K)+c] <= win_data[r*int'(K)+c+1];
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/linebuffer_kxk.md
Name: linebuffer_kxk

Overview:
Parametrised streaming sliding-window generator, the successor to the fixed 3x3/16-bit line buffer. It accepts a raster-order pixel stream with a valid qualifier and keeps K-1 line delays plus a KxK window register array. It emits a KxK window tagged with its output coordinates only when the window lies fully inside the image, so downstream conv PEs need no masking. Position: between the ifmap stream source and the conv MAC array.

Parameters:
DW, 16, pixel data width in bits
K, 3, window size (K >= 2)
IMG_W, 4, image width in pixels (>= K); also the depth of each line delay
IMG_H, 4, image height in pixels (>= K)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  in_data is valid this cycle; the pixel is accepted and the pipeline advances
in_data  input  DW  pixel, raster order, row-major
win_valid  output  1  win_data, win_row and win_col are valid (single-cycle pulse per window)
win_data  output  [K*K-1:0][DW-1:0]  window; index r*K+c, r=0 is the oldest row, c=0 is the oldest column (index 0 = top-left)
win_row  output  $clog2(IMG_H)  image row of the window's bottom-right pixel
win_col  output  $clog2(IMG_W)  image column of the window's bottom-right pixel
frame_done  output  1  one-cycle pulse, registered with the last pixel (row IMG_H-1, col IMG_W-1)

Behaviour:
- Reset (async assert, sync release): col/row counters 0. Window registers 0. win_valid, frame_done, win_row, win_col all 0. Line-delay contents need not be cleared; stale data is never exposed because the counters gate win_valid.
- Everything advances only on in_valid=1. With in_valid=0, all state holds: counters, line delays and window registers. win_valid and frame_done are 0 in that cycle.
- Line delay j (j=1..K-1) outputs the pixel accepted exactly j*IMG_W accepted pixels earlier. The delays are cascaded; each is an enabled shift of depth IMG_W.
- On accept, window row K-1 shifts in in_data, and window row K-1-j shifts in the output of line delay j. Columns shift toward c=0.
- win_valid is registered: it asserts on the cycle after accepting a pixel at (row,col) with row >= K-1 and col >= K-1. In that same cycle, win_row=row and win_col=col.
- Latency: pixel accepted at edge n appears in win_data after edge n+1.
- Window span: no windows straddle a row boundary. Row-wrap columns col < K-1 are suppressed.
- Counters: col counts 0..IMG_W-1 and wraps to 0 while incrementing row. row wraps from IMG_H-1 to 0, and frame_done pulses with that last pixel.
- Back-to-back frames need no gap. The first K-1 rows of a new frame produce no windows.
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- Windows per frame: (IMG_W-K+1)*(IMG_H-K+1).

Optional Feature:
LINEBUF_STRIDE2_EN
- Defined: win_valid is additionally gated so that (row-(K-1)) and (col-(K-1)) are both even (stride-2 convolution). Windows per frame become ceil((IMG_W-K+1)/2)*ceil((IMG_H-K+1)/2).
- Undefined: stride 1 as above.
- The datapath is identical in both cases; only the valid gating differs.

Decomposition:
- Package linebuf_pkg: default DW/K constants, and typedef pix_t = logic [DW-1:0] using the default width.
- Sub-module line_delay: enabled shift register, parameters DEPTH and WIDTH, ports clk, en, din, dout. Instantiated K-1 times via generate.
- Top module holds the counters, window array and valid logic.

Test Plan:
- Basic, K=3, 4x4, continuous valid, in_data=pixel index 0..15 -> exactly 4 win_valid pulses.
  - Pixel 10 -> win_data[0..8]={0,1,2,4,5,6,8,9,10}, win_row=2, win_col=2.
  - Last pixel -> {5,6,7,9,10,11,13,14,15}; frame_done with the pixel-15 window.
- Stalls: same frame with in_valid deasserted randomly (about 40%) -> identical window sequence. win_valid never high in a cycle following an in_valid=0 cycle.
- Back-to-back frames: two 4x4 frames, second = index+100 -> the first window of frame 2 is {100,101,102,104,105,106,108,109,110}, and no window mixes frames.
- Reset mid-frame: assert rst after pixel 6 of frame 1, then replay a full frame -> outputs 0 during reset, then the 4 correct windows.
- Generic K=5, IMG_W=8, IMG_H=6, DW=8 -> 8 windows. The first appears after pixel 36, with win_data[0]=0 and win_data[24]=36.
- LINEBUF_STRIDE2_EN with K=3 on a 5x5 frame -> 4 windows at (row,col) = (2,2), (2,4), (4,2), (4,4). Without the macro -> 9 windows.
